// File: rtl/bb_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// bb_lcd_ctrl
// Four-digit BCD run/stop counter driving a static (direct-drive) LCD.
//
// A single active-low pushbutton toggles the counter between STOP and RUN.
// While running, the count advances once per OP_DIV clock cycles. When the
// count passes 9999 it wraps to 0000 and the block parks in OVF until the
// button is pressed again. The LCD backplane is a square wave, and every
// segment is driven in or out of phase with it, so no segment ever sees DC.
//
// Ports
//   osc_sclk  in   1   clock, rising edge
//   rst       in   1   asynchronous reset, active-high
//   nbtn_run  in   1   run/stop pushbutton, active-low, asynchronous
//   clr       in   1   synchronous clear of count, flag and FSM
//   bp        out  1   LCD backplane drive
//   seg       out  28  segment drive, digit i on seg[7i+6:7i], bits g..a
//   bcd       out  16  BCD count, digit i on bcd[4i+3:4i], digit 0 = LSD
//   state     out  2   FSM state: 00 STOP, 01 RUN, 10 OVF
//   ovf       out  1   overflow flag, high while in OVF
// ---------------------------------------------------------------------------
module bb_lcd_ctrl #(
    parameter int DISP_DIV = 32,
    parameter int OP_DIV   = 2048,
    parameter int DEB_LEN  = 16
) (
    input  logic        osc_sclk,
    input  logic        rst,
    input  logic        nbtn_run,
    input  logic        clr,
    output logic        bp,
    output logic [27:0] seg,
    output logic [15:0] bcd,
    output logic [1:0]  state,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVF  = 2'b10
    } state_t;

    localparam int DISP_W = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
    localparam int OP_W   = (OP_DIV   > 1) ? $clog2(OP_DIV)   : 1;
    localparam int DEB_W  = (DEB_LEN  > 1) ? $clog2(DEB_LEN)  : 1;

    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_DIV - 1);
    localparam logic [OP_W-1:0]   OP_LAST   = OP_W'(OP_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_LEN - 1);

    // Standard 7-segment decode, lit = 1, bit order g..a; non-decimal codes blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Decimal ripple increment: a digit advances only when all lower digits were 9.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              stable_q, stable_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [DISP_W-1:0] disp_cnt_q, disp_cnt_d;
    logic              bp_q, bp_d;
    logic [OP_W-1:0]   op_cnt_q, op_cnt_d;
    state_t            state_q, state_d;
    logic [15:0]       bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              press_s;
    logic              tick_s;

    // Button synchronizer and debouncer; press fires on the edge the level falls.
    always_comb begin
        sync1_d   = nbtn_run;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        deb_cnt_d = '0;
        // The counter tracks how many consecutive samples disagree with the
        // accepted level; any agreeing sample restarts the count.
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d  = sync2_q;
                deb_cnt_d = '0;
            end else begin
                stable_d  = stable_q;
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
        press_s = stable_q & ~stable_d;
    end

    // Backplane prescaler: free-running in every state, bp flips at the wrap.
    always_comb begin
        if (disp_cnt_q == DISP_LAST) begin
            disp_cnt_d = '0;
            bp_d       = ~bp_q;
        end else begin
            disp_cnt_d = disp_cnt_q + DISP_W'(1);
            bp_d       = bp_q;
        end
    end

    // Run/stop/overflow FSM with op prescaler and BCD count; clr beats press beats tick.
    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        op_cnt_d = '0;
        tick_s   = (state_q == ST_RUN) && (op_cnt_q == OP_LAST);
        if (clr) begin
            state_d = ST_STOP;
            bcd_d   = 16'h0000;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    // op counter stays at zero so the first tick is a full period away
                    if (press_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_RUN: begin
                    if (press_s) begin
                        // a coincident tick is dropped; the count freezes as shown
                        state_d = ST_STOP;
                    end else if (tick_s) begin
                        op_cnt_d = '0;
                        if (bcd_q == 16'h9999) begin
                            state_d = ST_OVF;
                            bcd_d   = 16'h0000;
                            ovf_d   = 1'b1;
                        end else begin
                            bcd_d = bcd_inc(bcd_q);
                        end
                    end else begin
                        op_cnt_d = op_cnt_q + OP_W'(1);
                    end
                end
                ST_OVF: begin
                    if (press_s) begin
                        state_d = ST_STOP;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_OVF;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                    bcd_d   = 16'h0000;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset puts the button path at released and everything else at zero.
    always_ff @(posedge osc_sclk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            stable_q   <= 1'b1;
            deb_cnt_q  <= '0;
            disp_cnt_q <= '0;
            bp_q       <= 1'b0;
            op_cnt_q   <= '0;
            state_q    <= ST_STOP;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            disp_cnt_q <= disp_cnt_d;
            bp_q       <= bp_d;
            op_cnt_q   <= op_cnt_d;
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    // Segment drive: decoded digits inverted while bp is high, for zero net DC.
    always_comb begin
        seg = '0;
        for (int i = 0; i < 4; i++) begin
            seg[7*i +: 7] = seg7_decode(bcd_q[4*i +: 4]) ^ {7{bp_q}};
        end
    end

    assign bp    = bp_q;
    assign bcd   = bcd_q;
    assign state = state_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/bb_lcd_ctrl.md
BB_LCD_CTRL -- requirements
Module: bb_lcd_ctrl

Interface
REQ-001 Parameter DISP_DIV, default 32: osc_sclk cycles per backplane half-period (~78 Hz backplane at 5 kHz).
REQ-002 Parameter OP_DIV, default 2048: osc_sclk cycles per count tick (~2.4 Hz).
REQ-003 Parameter DEB_LEN, default 16: consecutive equal synchronized samples needed to accept a new button level.
REQ-004 osc_sclk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 nbtn_run  in  1  run/stop pushbutton, active-low, asynchronous to osc_sclk.
REQ-007 clr  in  1  synchronous clear, active-high.
REQ-008 bp  out  1  LCD backplane drive.
REQ-009 seg  out  28  segment drive: digit i on seg[7i+6:7i], bit order g..a.
REQ-010 bcd  out  16  4-digit BCD count: digit i on bcd[4i+3:4i], digit 0 least significant.
REQ-011 state  out  2  FSM state: 00 STOP, 01 RUN, 10 OVF.
REQ-012 ovf  out  1  overflow flag, high in OVF.

Function
REQ-013 Display prescaler: counts 0..DISP_DIV-1 continuously, in every FSM state; bp toggles on the cycle the prescaler is at DISP_DIV-1, so each bp level lasts exactly DISP_DIV cycles.
REQ-014 seg is combinational from registered bcd and bp: seg digit = decode(digit) XOR {7{bp}}, giving zero DC across every segment.
REQ-015 Decode is standard 7-segment, lit = 1 before the XOR; 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, g..a); codes 10-15 decode to 00.
REQ-016 nbtn_run passes through a 2-flop synchronizer, then a debouncer that updates its stable level only after DEB_LEN consecutive equal synchronized samples; reset stable level is 1 (released).
REQ-017 press = one-cycle pulse on a stable-level 1->0 transition; releases generate nothing; holding the button generates exactly one press.
REQ-018 Op counter: counts 0..OP_DIV-1 only in RUN; tick = one-cycle pulse when the op counter is at OP_DIV-1; the counter is forced to 0 in STOP and OVF, so the first tick comes exactly OP_DIV cycles after entering RUN.
REQ-019 On tick: digit 0 increments; digit i (i>0) increments only when digits 0..i-1 are all 9; any digit at 9 that increments becomes 0.
REQ-020 FSM transitions:
- STOP + press -> RUN.
- RUN + press -> STOP; bcd holds its value.
- RUN + tick with bcd = 9999 -> OVF; bcd becomes 0000 and ovf becomes 1 on the same edge.
- OVF + press -> STOP; ovf clears; bcd stays 0000.
- All other cases hold state.
REQ-021 In OVF, bcd holds and no ticks occur.
REQ-022 Priority: clr > press > tick; when clr is high, bcd = 0000, ovf = 0 and state = STOP on the next edge, from any state.
REQ-023 When press and tick coincide in RUN, the result is STOP and the tick is discarded (bcd does not increment).
REQ-024 All counters are unsigned and wrap only as specified; no BCD digit ever holds a value >9.

Reset
REQ-025 Asserting rst immediately forces: state STOP, bcd 0000, ovf 0, bp 0, all prescalers 0, synchronizer and debouncer at released (1).
REQ-026 Deasserting rst mid-operation resumes from the reset values; there is no spurious press.

Verification (DISP_DIV=4, OP_DIV=8, DEB_LEN=4)
REQ-027 Reset, then idle for 20 cycles: bp toggles every 4 cycles; seg = ~3F per digit while bp=1 and 3F while bp=0; bcd stays 0000; state stays 00.
REQ-028 Press held for 10 cycles, then released: state becomes 01 about 6 cycles later; first tick 8 cycles after entering RUN; bcd = 0001; no second press while the button is held.
REQ-029 Preload to 0999 by running, then one tick: bcd = 1000; then 9999 + tick: bcd = 0000, ovf = 1, state 10; bcd then stays 0000 for a further 40 cycles.
REQ-030 Bounce: nbtn_run toggled every 2 cycles for 20 cycles, then held low: exactly one press is seen; state changes once.
REQ-031 clr asserted in RUN on the same cycle as a tick and a press: next state STOP, bcd 0000, ovf 0.
REQ-032 rst asserted mid-count at bcd 0042: all outputs take their reset values immediately, without waiting for a clock edge.
